// File: rtl/keypad_if.sv
// Keypad encoder pin/strobe bundle: row sense in, column drive and key events out.
interface keypad_if;
    logic [3:0] rows;
    logic [3:0] col;
    logic       keystrobe;
    logic [3:0] keycode;
    logic       key_down;

    modport master (input rows, output col, keystrobe, keycode, key_down);
    modport slave  (output rows, input col, keystrobe, keycode, key_down);
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: one-hot column scan, press/release debounce,
// one keystrobe with keycode per debounced press, no auto-repeat.
module keypad_encoder #(
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int MAXC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, STROBE, RELEASE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    cidx, cidx_nx;
    logic [1:0]    ridx, ridx_nx;
    logic [3:0]    keycode_q, keycode_nx;
    logic [3:0]    rows_m, rows_s;
    logic [1:0]    row_low;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'd1;   4'h1: key_map = 4'd2;
            4'h2: key_map = 4'd3;   4'h3: key_map = 4'd10;
            4'h4: key_map = 4'd4;   4'h5: key_map = 4'd5;
            4'h6: key_map = 4'd6;   4'h7: key_map = 4'd11;
            4'h8: key_map = 4'd7;   4'h9: key_map = 4'd8;
            4'ha: key_map = 4'd9;   4'hb: key_map = 4'd12;
            4'hc: key_map = 4'd14;  4'hd: key_map = 4'd0;
            4'he: key_map = 4'd15;  default: key_map = 4'd13;
        endcase
    endfunction

    // rows is asynchronous to clk; only the second stage is ever used
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_m <= '0;
            rows_s <= '0;
        end else begin
            rows_m <= kp.rows;
            rows_s <= rows_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            cnt       <= '0;
            cidx      <= '0;
            ridx      <= '0;
            keycode_q <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cidx      <= cidx_nx;
            ridx      <= ridx_nx;
            keycode_q <= keycode_nx;
        end
    end

    // lowest active row wins when several are sensed together
    always_comb begin
        row_low = 2'd3;
        if      (rows_s[0]) row_low = 2'd0;
        else if (rows_s[1]) row_low = 2'd1;
        else if (rows_s[2]) row_low = 2'd2;
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        cidx_nx    = cidx;
        ridx_nx    = ridx;
        keycode_nx = keycode_q;
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_nx = '0;
                    if (|rows_s) begin
                        state_nx = DEBOUNCE;
                        ridx_nx  = row_low;
                    end else begin
                        cidx_nx = cidx + 2'd1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rows_s[ridx]) begin
                    if (cnt == DB_LAST) begin
                        state_nx   = STROBE;
                        cnt_nx     = '0;
                        keycode_nx = key_map(ridx, cidx);
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    state_nx = SCAN;
                    cnt_nx   = '0;
                    cidx_nx  = cidx + 2'd1;
                end
            end
            STROBE: begin
                state_nx = RELEASE;
                cnt_nx   = '0;
            end
            RELEASE: begin
                // count consecutive released cycles; any re-press restarts the count
                if (!rows_s[ridx]) begin
                    if (cnt == DB_LAST) begin
                        state_nx = SCAN;
                        cnt_nx   = '0;
                        cidx_nx  = cidx + 2'd1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else begin
                    cnt_nx = '0;
                end
            end
            default: begin
                state_nx = SCAN;
                cnt_nx   = '0;
            end
        endcase
    end

    assign kp.col       = 4'b0001 << cidx;
    assign kp.keystrobe = (state == STROBE);
    assign kp.key_down  = (state == STROBE) || (state == RELEASE);
    assign kp.keycode   = keycode_q;
endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a switch-matrix model of the keypad.
module tb_keypad_encoder;
    localparam int SC = 4;
    localparam int DC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    keypad_if kif();

    keypad_encoder #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    always #5 clk = ~clk;

    // pressed[r][c]: a closed switch connects column c drive to row r sense
    logic [3:0][3:0] pressed;
    logic [3:0]      rows_v;
    always_comb begin
        rows_v = '0;
        for (int r = 0; r < 4; r++) rows_v[r] = |(pressed[r] & kif.col);
    end
    assign kif.rows = rows_v;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_strobe = 0;
    int         strobe_cyc = 0;
    logic [3:0] strobe_code = '0;
    logic       prev_ks = 1'b0;
    int         t0, s0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            chk("col_onehot", $countones(kif.col), 1);
            if (kif.keystrobe) begin
                chk("strobe_gap", prev_ks, 1'b0);
                n_strobe++;
                strobe_cyc  = cyc;
                strobe_code = kif.keycode;
            end
        end
        prev_ks = kif.keystrobe;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_col(input logic [3:0] v, input int budget, input string tag);
        int n = 0;
        while (kif.col !== v && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, kif.col, v);
    endtask

    task automatic wait_strobe(input int exp, input int budget, input string tag);
        int n = 0;
        while (n_strobe < exp && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, n_strobe, exp);
    endtask

    task automatic wait_keyup(input int budget, input string tag);
        int n = 0;
        while (kif.key_down !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, kif.key_down, 1'b0);
    endtask

    task automatic do_press(input int r, input int c, input logic [3:0] code, input string tag);
        int s;
        s = n_strobe;
        pressed[r][c] = 1'b1;
        wait_strobe(s + 1, 200, {tag, "_strobe"});
        chk({tag, "_code"}, strobe_code, code);
        step(3);
        pressed = '0;
        wait_keyup(50, {tag, "_keyup"});
        step(2);
        chk({tag, "_count"}, n_strobe, s + 1);
    endtask

    initial begin
        pressed = '0;
        step(3);
        // reset state
        chk("rst_col", kif.col, 4'b0001);
        chk("rst_ks",  kif.keystrobe, 1'b0);
        chk("rst_kc",  kif.keycode, 4'd0);
        chk("rst_kd",  kif.key_down, 1'b0);
        rst = 1'b0;
        chk("scan_c0_first", kif.col, 4'b0001);
        step(3); chk("scan_c0_last", kif.col, 4'b0001);
        step(1); chk("scan_c1", kif.col, 4'b0010);
        step(4); chk("scan_c2", kif.col, 4'b0100);
        step(4); chk("scan_c3", kif.col, 4'b1000);
        step(4); chk("scan_wrap", kif.col, 4'b0001);

        // press '5' at the first cycle of column 1 dwell, hold 60 cycles
        wait_col(4'b0001, 40, "k5_sync0");
        wait_col(4'b0010, 40, "k5_sync1");
        t0 = cyc; s0 = n_strobe;
        pressed[1][1] = 1'b1;
        step(60);
        chk("k5_count", n_strobe - s0, 1);
        chk("k5_code", strobe_code, 4'd5);
        chk("k5_latency", strobe_cyc - t0, 12);
        chk("k5_down_held", kif.key_down, 1'b1);
        pressed = '0;
        step(9); chk("k5_down_last", kif.key_down, 1'b1);
        step(1); chk("k5_down_fall", kif.key_down, 1'b0);
        step(30); chk("k5_no_repeat", n_strobe - s0, 1);

        // bounce: r0 in col0 for 5 cycles
        wait_col(4'b1000, 40, "bnc_sync0");
        wait_col(4'b0001, 40, "bnc_sync1");
        s0 = n_strobe;
        pressed[0][0] = 1'b1;
        step(5);
        pressed = '0;
        step(1); chk("bnc_col_held", kif.col, 4'b0001);
        step(2); chk("bnc_resume", kif.col, 4'b0010);
        step(20); chk("bnc_no_strobe", n_strobe, s0);
        do_press(3, 3, 4'd13, "keyD");

        // two rows at once in col0, then '*'
        s0 = n_strobe;
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        wait_strobe(s0 + 1, 200, "multi_strobe");
        chk("multi_code", strobe_code, 4'd1);
        step(3);
        pressed = '0;
        wait_keyup(50, "multi_keyup");
        step(2);
        do_press(3, 0, 4'd14, "star");

        // release glitch on '9'
        s0 = n_strobe;
        pressed[2][2] = 1'b1;
        wait_strobe(s0 + 1, 200, "k9_strobe");
        chk("k9_code", strobe_code, 4'd9);
        step(3);
        pressed[2][2] = 1'b0;
        step(5);
        pressed[2][2] = 1'b1;
        step(3); chk("k9_glitch_down", kif.key_down, 1'b1);
        step(20);
        chk("k9_no_restrobe", n_strobe, s0 + 1);
        chk("k9_still_down", kif.key_down, 1'b1);
        pressed = '0;
        wait_keyup(50, "k9_keyup");
        step(2);

        // reset 4 cycles into debounce of '0'
        wait_col(4'b0001, 40, "k0_sync0");
        wait_col(4'b0010, 40, "k0_sync1");
        pressed[3][1] = 1'b1;
        step(7);
        rst = 1'b1;
        #1;
        chk("k0_rst_col", kif.col, 4'b0001);
        chk("k0_rst_ks",  kif.keystrobe, 1'b0);
        chk("k0_rst_kc",  kif.keycode, 4'd0);
        chk("k0_rst_kd",  kif.key_down, 1'b0);
        s0 = n_strobe;
        step(2);
        rst = 1'b0;
        t0 = cyc;
        wait_strobe(s0 + 1, 200, "k0_strobe");
        chk("k0_code", strobe_code, 4'd0);
        chk("k0_latency", strobe_cyc - t0, 16);
        step(3);
        pressed = '0;
        wait_keyup(50, "k0_keyup");
        step(5);
        chk("k0_count", n_strobe, s0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Scans a 4x4 matrix keypad, debounces presses, and emits one `keystrobe` pulse with a 4-bit `keycode` per debounced press. It sits between the keypad pins and the digit decoder, which accepts `keystrobe`/`keycode` directly. Codes 0-9 are digits; codes 10-15 are the non-digit keys. A held key never auto-repeats.

## Interface

**Parameters**
- `SCAN_CYCLES`, default 16: dwell per column in clocks. Must be ≥4.
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles required for press and for release. Must be ≥1.

**Ports**
- `clk`  in  1: single system clock. All logic uses the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rows`  in  4: keypad row sense, active-high, pulled down externally. Asynchronous to `clk`.
- `col`  out  4: one-hot column drive, active-high.
- `keystrobe`  out  1: one-cycle pulse per debounced press.
- `keycode`  out  4: code of the last pressed key. Holds its value between strobes.
- `key_down`  out  1: high from the strobe cycle until release is debounced.

## Operation

**Synchronizer**
- `rows` passes through a 2-flop synchronizer into `rows_s`. Only `rows_s` is used internally.

**Key map (row r, column c -> keycode)**
- r0: 1, 2, 3, 10(A)
- r1: 4, 5, 6, 11(B)
- r2: 7, 8, 9, 12(C)
- r3: 14(*), 0, 15(#), 13(D)

**State machine**
- Reset state: SCAN, column index 0. Reset values: `col`=0001, `keystrobe`=0, `keycode`=0, `key_down`=0. All counters are 0.
- SCAN
  - Drive column c for `SCAN_CYCLES` cycles, then advance c, wrapping 3 -> 0.
  - `rows_s` is sampled only on the last dwell cycle.
  - If that sample is nonzero: latch r = lowest set bit and go to DEBOUNCE, holding column c. Higher rows are ignored.
  - If the sample is zero: advance the column.
- DEBOUNCE
  - Counts cycles in which `rows_s[r]`=1.
  - If any cycle has `rows_s[r]`=0: return to SCAN at column (c+1) mod 4 and clear the counter.
  - After `DEBOUNCE_CYCLES` consecutive good cycles: go to STROBE.
- STROBE (one cycle)
  - `keystrobe`=1.
  - `keycode` is registered from the map on entry, so it is valid in this cycle.
  - `key_down`=1.
  - Next state: RELEASE.
- RELEASE
  - Hold column c and keep `key_down`=1.
  - Count consecutive cycles with `rows_s[r]`=0. Any cycle with `rows_s[r]`=1 clears the count.
  - At `DEBOUNCE_CYCLES`: `key_down`=0, go to SCAN at column (c+1) mod 4.
  - Other rows pressed during RELEASE are ignored.

**Reset**
- `rst` asserted in any state, including mid-debounce or mid-strobe, immediately forces the reset values.
- A key still held after reset is rescanned and requires a full debounce before it strobes.

## Timing

**Latency**
- Let T be the SCAN detection cycle.
- DEBOUNCE occupies T+1..T+`DEBOUNCE_CYCLES`.
- `keystrobe` is high in cycle T+`DEBOUNCE_CYCLES`+1 only.
- From the pin edge, add 2 sync cycles plus the remaining column dwell and scan position. Worst case from pin edge to strobe is 4·`SCAN_CYCLES` + `DEBOUNCE_CYCLES` + 3 cycles.

**Output timing**
- `keystrobe` is high for exactly 1 cycle per press. It is never high on consecutive cycles.
- `keycode` changes only in a strobe cycle.
- `key_down` rises in the strobe cycle. It falls in the cycle after the `DEBOUNCE_CYCLES`-th consecutive released cycle.
- `col` is always one-hot and changes only in SCAN, or when SCAN is re-entered.

**Counters**
- Counters are sized $clog2(max(`SCAN_CYCLES`, `DEBOUNCE_CYCLES`)+1).
- Counters never wrap: they saturate or clear on every state change.

## Test plan

All scenarios use `SCAN_CYCLES`=4 and `DEBOUNCE_CYCLES`=8 unless noted.

- **Reset:** assert `rst` with no key, then release it.
  - Required: `col`=0001, `keystrobe`=0, `keycode`=0, `key_down`=0.
  - `col` then steps 0001 -> 0010 -> 0100 -> 1000 -> 0001, 4 cycles per column.
- **Press '5':** hold r1 whenever `col`=0010, for 60 cycles, then release.
  - Required: exactly one `keystrobe` with `keycode`=5, 9 cycles after detection.
  - `key_down` falls 8 released cycles after release.
  - No second strobe.
- **Bounce:** assert r0 in col0 for 5 cycles, then drop it.
  - Required: no strobe; scanning resumes at `col`=0010.
  - Then press 'D' (r3, col3) cleanly. Required: `keycode`=13.
- **Multiple rows:** press r0 and r2 together in col0.
  - Required: `keycode`=1 (lowest row wins).
  - Then press '*' alone. Required: `keycode`=14.
- **Release glitch:** while '9' is held after its strobe, drop r2 for 5 cycles, then reassert it.
  - Required: no new strobe; `key_down` stays 1.
  - A full release then clears `key_down`.
- **Reset mid-debounce:** assert `rst` 4 cycles into DEBOUNCE of '0' while the key stays held.
  - Required: reset values immediately.
  - After reset, one strobe with `keycode`=0 only after a complete rescan and debounce.
